// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: ALU op codes and multiply/divide sequencer states
package cpu_types_pkg;
    typedef enum logic [4:0] {
        OP_SLL, OP_SRL, OP_SRA, OP_ADD, OP_ADDU, OP_SUB, OP_SUBU,
        OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
        OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO,
        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
    } aluop_w_t;
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} muldiv_state_t;
endpackage

// File: rtl/alu_basic.sv
// alu_basic: combinational single-cycle ALU ops with signed overflow detection
module alu_basic
    import cpu_types_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  aluop_w_t         op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] res,
    output logic             over
);
    localparam int SW = $clog2(WIDTH);
    logic [SW-1:0] sh;
    logic [WIDTH-1:0] sum, dif;
    assign sh = b[SW-1:0];
    assign sum = a + b;
    assign dif = a - b;
    always_comb begin
        res = '0;
        case (op)
            OP_SLL:           res = a << sh;
            OP_SRL:           res = a >> sh;
            OP_SRA:           res = $signed(a) >>> sh;
            OP_ADD, OP_ADDU:  res = sum;
            OP_SUB, OP_SUBU:  res = dif;
            OP_AND:           res = a & b;
            OP_OR:            res = a | b;
            OP_XOR:           res = a ^ b;
            OP_NOR:           res = ~(a | b);
            OP_SLT:           res = WIDTH'($signed(a) < $signed(b));
            OP_SLTU:          res = WIDTH'(a < b);
            OP_MFHI:          res = hi;
            OP_MFLO:          res = lo;
            OP_MTHI, OP_MTLO: res = a;
            default:          res = '0;
        endcase
        over = (op == OP_ADD) ? (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1])
             : (op == OP_SUB) ? (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1])
             : 1'b0;
    end
endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: registered ALU with iterative multiply/divide and HI/LO registers
module alu_muldiv
    import cpu_types_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] porta,
    input  logic [WIDTH-1:0] portb,
    input  logic             kill,
    output logic             resp_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             zero_f,
    output logic             neg_f,
    output logic             over_f,
    output logic             div0_f
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
    muldiv_state_t state, state_nxt;
    aluop_w_t opc;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] acc, aux, opnd, acc_nxt, aux_nxt, opnd_nxt;
    logic [WIDTH-1:0] basic_res, mag_a, mag_b, acc_st, aux_st, dv_sub, res_nxt, hi_nxt, lo_nxt;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0] mul_sum, dv_t;
    logic neg_q, neg_r, neg_q_nxt, neg_r_nxt;
    logic basic_ov, accept, is_mul, is_div, sgn, sa, sb, div_ge;
    logic rsp, ov_nxt, dz_nxt, hi_we, lo_we;

    assign opc = aluop_w_t'(op[4:0]);
    assign req_ready = state == S_IDLE;
    assign accept = req_valid && req_ready && !kill;
    assign is_mul = opc == OP_MULT || opc == OP_MULTU;
    assign is_div = opc == OP_DIV || opc == OP_DIVU;
    assign sgn = opc == OP_MULT || opc == OP_DIV;
    assign sa = sgn && porta[WIDTH-1];
    assign sb = sgn && portb[WIDTH-1];
    assign mag_a = sa ? -porta : porta;
    assign mag_b = sb ? -portb : portb;
    assign mul_sum = {1'b0, acc} + (aux[0] ? {1'b0, opnd} : '0);
    assign dv_t = {acc, aux[WIDTH-1]};
    assign dv_sub = dv_t[WIDTH-1:0] - opnd;
    assign div_ge = dv_t >= {1'b0, opnd};
    assign acc_st = state == S_MUL ? mul_sum[WIDTH:1] : div_ge ? dv_sub : dv_t[WIDTH-1:0];
    assign aux_st = state == S_MUL ? {mul_sum[0], aux[WIDTH-1:1]} : {aux[WIDTH-2:0], div_ge};
    assign prod = neg_q ? -{acc_st, aux_st} : {acc_st, aux_st};

    alu_basic #(.WIDTH(WIDTH)) u_basic (
        .op(opc), .a(porta), .b(portb), .hi(hi), .lo(lo), .res(basic_res), .over(basic_ov)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt = cnt;
        acc_nxt = acc;
        aux_nxt = aux;
        opnd_nxt = opnd;
        neg_q_nxt = neg_q;
        neg_r_nxt = neg_r;
        rsp = 1'b0;
        res_nxt = basic_res;
        ov_nxt = 1'b0;
        dz_nxt = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        hi_nxt = porta;
        lo_nxt = porta;
        case (state)
            S_IDLE: if (accept) begin
                if (is_div && portb == '0) begin
                    state_nxt = S_DONE;
                    rsp = 1'b1;
                    dz_nxt = 1'b1;
                    hi_we = 1'b1;
                    lo_we = 1'b1;
                    lo_nxt = '1;
                    res_nxt = '1;
                end else if (opc == OP_DIV && porta == MIN && portb == '1) begin
                    state_nxt = S_DONE;
                    rsp = 1'b1;
                    ov_nxt = 1'b1;
                    hi_we = 1'b1;
                    lo_we = 1'b1;
                    hi_nxt = '0;
                    res_nxt = porta;
                end else if (is_mul || is_div) begin
                    state_nxt = is_mul ? S_MUL : S_DIV;
                    cnt_nxt = CW'(WIDTH - 1);
                    acc_nxt = '0;
                    aux_nxt = is_mul ? mag_b : mag_a;
                    opnd_nxt = is_mul ? mag_a : mag_b;
                    neg_q_nxt = sa ^ sb;
                    neg_r_nxt = sa;
                end else begin
                    rsp = 1'b1;
                    ov_nxt = basic_ov;
                    hi_we = opc == OP_MTHI;
                    lo_we = opc == OP_MTLO;
                end
            end
            S_MUL, S_DIV: if (kill) begin
                state_nxt = S_IDLE;
            end else begin
                acc_nxt = acc_st;
                aux_nxt = aux_st;
                cnt_nxt = cnt - 1'b1;
                if (cnt == '0) begin
                    state_nxt = S_DONE;
                    rsp = 1'b1;
                    hi_we = 1'b1;
                    lo_we = 1'b1;
                    {hi_nxt, lo_nxt} = state == S_MUL ? prod
                        : {neg_r ? -acc_st : acc_st, neg_q ? -aux_st : aux_st};
                    res_nxt = lo_nxt;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
            cnt <= '0;
            acc <= '0;
            aux <= '0;
            opnd <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            hi <= '0;
            lo <= '0;
            result <= '0;
            resp_valid <= 1'b0;
            zero_f <= 1'b0;
            neg_f <= 1'b0;
            over_f <= 1'b0;
            div0_f <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt <= cnt_nxt;
            acc <= acc_nxt;
            aux <= aux_nxt;
            opnd <= opnd_nxt;
            neg_q <= neg_q_nxt;
            neg_r <= neg_r_nxt;
            resp_valid <= rsp;
            zero_f <= rsp && res_nxt == '0;
            neg_f <= rsp && res_nxt[WIDTH-1];
            over_f <= rsp && ov_nxt;
            div0_f <= rsp && dz_nxt;
            if (rsp) result <= res_nxt;
            if (hi_we) hi <= hi_nxt;
            if (lo_we) lo <= lo_nxt;
        end
    end
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed and random checks of alu_muldiv against an arithmetic reference model
module tb_alu_muldiv;
    import cpu_types_pkg::*;
    localparam int W = 32;
    localparam logic [W-1:0] MINV = 32'h8000_0000;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic req_valid = 1'b0;
    logic kill = 1'b0;
    logic [4:0] op = '0;
    logic [W-1:0] porta = '0;
    logic [W-1:0] portb = '0;
    logic req_ready, resp_valid, zero_f, neg_f, over_f, div0_f;
    logic [W-1:0] result, hi, lo;
    logic [W-1:0] hi_m = '0;
    logic [W-1:0] lo_m = '0;
    int n_chk = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    alu_muldiv #(.WIDTH(W), .OPW(5)) dut (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready), .op(op),
        .porta(porta), .portb(portb), .kill(kill), .resp_valid(resp_valid), .result(result),
        .hi(hi), .lo(lo), .zero_f(zero_f), .neg_f(neg_f), .over_f(over_f), .div0_f(div0_f)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run(input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] er, eh, el;
        logic eo, ed, md;
        logic [63:0] p;
        int lat_e, lat, busy;
        string t;
        er = '0;
        eh = hi_m;
        el = lo_m;
        eo = 1'b0;
        ed = 1'b0;
        md = 1'b0;
        lat_e = 1;
        case (o)
            OP_SLL: er = a << b[4:0];
            OP_SRL: er = a >> b[4:0];
            OP_SRA: er = $signed(a) >>> b[4:0];
            OP_ADD, OP_ADDU: begin
                er = a + b;
                eo = (o == OP_ADD) && (longint'($signed(a)) + longint'($signed(b)) != longint'($signed(er)));
            end
            OP_SUB, OP_SUBU: begin
                er = a - b;
                eo = (o == OP_SUB) && (longint'($signed(a)) - longint'($signed(b)) != longint'($signed(er)));
            end
            OP_AND: er = a & b;
            OP_OR: er = a | b;
            OP_XOR: er = a ^ b;
            OP_NOR: er = ~(a | b);
            OP_SLT: er = ($signed(a) < $signed(b)) ? 1 : 0;
            OP_SLTU: er = (a < b) ? 1 : 0;
            OP_MFHI: er = hi_m;
            OP_MFLO: er = lo_m;
            OP_MTHI: begin eh = a; er = a; end
            OP_MTLO: begin el = a; er = a; end
            OP_MULT, OP_MULTU: begin
                if (o == OP_MULT) p = longint'($signed(a)) * longint'($signed(b));
                else p = {32'b0, a} * {32'b0, b};
                {eh, el} = p;
                er = el;
                md = 1'b1;
                lat_e = W + 1;
            end
            OP_DIV, OP_DIVU: begin
                md = 1'b1;
                if (b == 0) begin
                    el = '1;
                    eh = a;
                    ed = 1'b1;
                end else if (o == OP_DIV && a == MINV && b == '1) begin
                    el = a;
                    eh = '0;
                    eo = 1'b1;
                end else begin
                    lat_e = W + 1;
                    if (o == OP_DIV) begin
                        el = $signed(a) / $signed(b);
                        eh = $signed(a) % $signed(b);
                    end else begin
                        el = a / b;
                        eh = a % b;
                    end
                end
                er = el;
            end
            default: er = '0;
        endcase
        t = $sformatf("op%0d a=%h b=%h", o, a, b);
        chk({"ready_before ", t}, req_ready, 1);
        op = o;
        porta = a;
        portb = b;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        lat = 1;
        busy = req_ready ? 0 : 1;
        while (!resp_valid && lat < 60) begin
            step();
            lat++;
            if (!req_ready) busy++;
        end
        chk({"latency ", t}, lat, lat_e);
        chk({"busy_cycles ", t}, busy, md ? lat_e : 0);
        chk({"result ", t}, result, er);
        chk({"hi ", t}, hi, eh);
        chk({"lo ", t}, lo, el);
        chk({"flags zvod ", t}, {zero_f, neg_f, over_f, div0_f}, {er == 0, er[W-1], eo, ed});
        hi_m = eh;
        lo_m = el;
        if (md) begin
            step();
            chk({"ready_after_done ", t}, req_ready, 1);
            chk({"idle_outputs ", t}, {resp_valid, zero_f, neg_f, over_f, div0_f}, 0);
        end
    endtask

    logic [4:0] pool [22];
    logic [W-1:0] spec [6];
    logic [4:0] ro;
    logic [W-1:0] ra, rb;
    int seen;

    initial begin
        pool = '{OP_SLL, OP_SRL, OP_SRA, OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR,
                 OP_NOR, OP_SLT, OP_SLTU, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO, OP_MULT, OP_MULTU,
                 OP_DIV, OP_DIVU, 5'd27};
        spec = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7};
        step();
        step();
        chk("reset ready", req_ready, 1);
        chk("reset resp_valid", resp_valid, 0);
        chk("reset result", result, 0);
        chk("reset hi", hi, 0);
        chk("reset lo", lo, 0);
        chk("reset flags", {zero_f, neg_f, over_f, div0_f}, 0);
        RST = 1'b0;
        run(OP_ADD, 32'h7FFF_FFFF, 32'h1);
        run(OP_SUBU, 32'd5, 32'd7);
        run(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        run(OP_MFHI, 32'h0, 32'h0);
        run(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        run(OP_DIVU, 32'd100, 32'd7);
        run(OP_DIVU, 32'd5, 32'd0);
        run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run(OP_SUB, 32'h8000_0000, 32'h1);
        run(OP_SRA, 32'h8000_0010, 32'h24);
        run(5'd30, 32'h1234, 32'h5678);
        run(OP_MTHI, 32'hAAAA_5555, 32'h0);
        run(OP_MTLO, 32'h1357_9BDF, 32'h0);
        op = OP_MULTU;
        porta = 32'hDEAD_BEEF;
        portb = 32'h1234_5678;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        repeat (9) step();
        kill = 1'b1;
        step();
        kill = 1'b0;
        chk("kill ready", req_ready, 1);
        chk("kill resp_valid", resp_valid, 0);
        chk("kill hi", hi, hi_m);
        chk("kill lo", lo, lo_m);
        seen = 0;
        repeat (40) begin
            step();
            if (resp_valid) seen++;
        end
        chk("kill no late resp", seen, 0);
        op = OP_ADD;
        porta = 32'd1;
        portb = 32'd1;
        req_valid = 1'b1;
        kill = 1'b1;
        step();
        req_valid = 1'b0;
        kill = 1'b0;
        chk("kill idle drop", resp_valid, 0);
        for (int i = 0; i < 40; i++) begin
            ro = pool[$urandom_range(0, 21)];
            ra = ($urandom_range(0, 3) == 0) ? spec[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'h0
               : ($urandom_range(0, 3) == 0) ? spec[$urandom_range(0, 5)] : $urandom;
            run(ro, ra, rb);
        end
        op = OP_DIV;
        porta = 32'h1234_5678;
        portb = 32'd3;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        repeat (5) step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("rst mid-div ready", req_ready, 1);
        chk("rst mid-div resp_valid", resp_valid, 0);
        chk("rst mid-div hi", hi, 0);
        chk("rst mid-div lo", lo, 0);
        hi_m = '0;
        lo_m = '0;
        run(OP_MFLO, 32'h0, 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised, multi-cycle successor to the single-cycle execute ALU.
- Performs all single-cycle ALU ops in one registered cycle. Adds iterative signed/unsigned multiply and divide, with HI/LO result registers and a valid/ready request handshake.
- Sits in the EX stage. The hazard unit stalls on req_ready=0 and can abort an in-flight op with kill.

Parameters:
- WIDTH, 32, datapath width in bits; must be ≥4 and even.
- OPW, 5, op-code width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- op  in  OPW  operation, aluop_w_t from the package.
- porta  in  WIDTH  operand A.
- portb  in  WIDTH  operand B, already muxed (imm/shamt/reg).
- kill  in  1  abort the in-flight multi-cycle op (pipeline flush).
- resp_valid  out  1  one-cycle pulse: result and flags are valid.
- result  out  WIDTH  op result; LO for MULT/DIV.
- hi  out  WIDTH  architectural HI register.
- lo  out  WIDTH  architectural LO register.
- zero_f  out  1  result == 0.
- neg_f  out  1  result[WIDTH-1].
- over_f  out  1  signed overflow: ADD/SUB, and DIV of MIN by -1.
- div0_f  out  1  divide by zero.

Behaviour:
- Reset:
  - state=IDLE; hi, lo, result and all flags = 0; resp_valid=0; req_ready=1 on the cycle after reset.
  - RST mid-operation abandons the op; HI/LO are cleared.
- FSM states: IDLE, MUL, DIV, DONE.
  - req_ready=1 only in IDLE.
  - A request is accepted on a cycle with req_valid & req_ready & ~kill.
- Single-cycle ops (SLL, SRL, SRA, ADD, ADDU, SUB, SUBU, AND, OR, XOR, NOR, SLT, SLTU, MFHI, MFLO, MTHI, MTLO):
  - result and flags registered; resp_valid=1 the next cycle; state stays IDLE.
  - Throughput: one op per cycle.
  - Shifts use portb[$clog2(WIDTH)-1:0] only.
  - MTHI/MTLO write porta into HI/LO; result=porta.
- MULT/MULTU:
  - Operands latched; signed ops convert to magnitudes, product sign = sa^sb.
  - Shift-add runs WIDTH cycles in MUL, then DONE for one cycle.
  - In DONE: {hi,lo} = 2·WIDTH product (negated if the sign flag is set); result=lo; resp_valid=1.
  - Accept-to-resp_valid latency = WIDTH+1 cycles.
  - IDLE re-entered the cycle after DONE.
- DIV/DIVU:
  - Restoring division, WIDTH cycles in DIV, then DONE; same latency as multiply.
  - lo = quotient, hi = remainder.
  - Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide-by-zero (portb==0):
  - No iteration; DONE on the next cycle (latency 1).
  - lo = all ones, hi = porta, div0_f=1.
- Signed DIV, porta=MIN, portb=-1:
  - Latency 1; lo=MIN, hi=0, over_f=1.
- Flags:
  - zero_f and neg_f are computed from result for every op.
  - over_f only for ADD, SUB, and the DIV MIN/-1 case; ADDU/SUBU never set it.
  - div0_f only for DIV/DIVU.
  - All flags are 0 whenever resp_valid=0.
- kill:
  - In MUL/DIV: next state=IDLE; no resp_valid; HI/LO unchanged.
  - In IDLE with req_valid: the request is dropped.
  - In DONE: ignored; the response completes.
- HI/LO: written only in DONE, by MTHI/MTLO, or by RST.
- Unknown op code: result=0, resp_valid=1, no HI/LO write.

Decomposition:
- Package cpu_types_pkg additions:
  - aluop_w_t enum (OPW bits), including the MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO codes.
  - muldiv_state_t enum.
- Sub-module alu_basic (combinational, parametrised by WIDTH): single-cycle ops plus flags.
- alu_muldiv holds the FSM, iteration counter, HI/LO registers and the output registers.

Test Plan (WIDTH=32):
- ADD 0x7FFFFFFF+1 then back-to-back SUBU 5-7 → resp next cycle each: 0x80000000 with over_f=1, neg_f=1; then 0xFFFFFFFE with over_f=0; req_ready stays 1.
- MULT -3 × 7 → req_ready low for 33 cycles; resp_valid at accept+33; hi=0xFFFFFFFF, lo=0xFFFFFFEB; MFHI returns 0xFFFFFFFF.
- DIV -7 ÷ 2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU 100 ÷ 7 → lo=14, hi=2, latency 33.
- DIVU 5 ÷ 0 → resp_valid next cycle; lo=0xFFFFFFFF, hi=5, div0_f=1. DIV 0x80000000 ÷ -1 → lo=0x80000000, hi=0, over_f=1.
- Start MULTU, assert kill at cycle 10 → no resp_valid; req_ready=1 next cycle; HI/LO keep their prior values.
- Assert RST mid-DIV → next cycle req_ready=1, hi=lo=0, resp_valid=0.
